// File: rtl/mux8way_rr_arbiter.sv
// Eight-channel round-robin arbiter feeding a one-word output register.
// The grant search starts at the channel after the last winner; drain and refill can share a cycle.
module mux8way_rr_arbiter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [7:0]           in_valid,
   input  logic [8*WIDTH-1:0]   in_data,
   output logic [7:0]           in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic [2:0]           out_sel,
   input  logic                 out_ready
);

   localparam int unsigned N_CH  = 8;
   localparam int unsigned PTR_W = 3;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [WIDTH-1:0]   data_q, data_d;
   logic [PTR_W-1:0]   sel_q, sel_d;

   logic               grant_slot;
   logic               found;
   logic [PTR_W-1:0]   win;
   logic [PTR_W-1:0]   idx;
   logic [WIDTH-1:0]   win_word;

   // State register; reset discards any held word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   end

   // Round-robin search, grant generation and next-state logic.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      data_d     = data_q;
      sel_d      = sel_q;
      in_ready   = '0;
      found      = 1'b0;
      win        = '0;
      idx        = '0;
      win_word   = '0;
      grant_slot = (state_q == EMPTY) || out_ready;

      for (int i = 0; i < N_CH; i++) begin
         idx = ptr_q + PTR_W'(i);
         if (!found && in_valid[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end

      for (int k = 0; k < N_CH; k++) begin
         if (win == PTR_W'(k)) begin
            win_word = in_data[k*WIDTH +: WIDTH];
         end
      end

      if (grant_slot) begin
         if (found) begin
            // Reset gating keeps the grant low while the flops are held in reset.
            in_ready[win] = !reset;
            state_d       = FULL;
            data_d        = win_word;
            sel_d         = win;
            ptr_d         = win + PTR_W'(1);
         end else begin
            state_d = EMPTY;
         end
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_data  = data_q;
   assign out_sel   = sel_q;

endmodule

// File: tb/tb_mux8way_rr_arbiter.sv
// Self-checking bench for mux8way_rr_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbiter.
module tb_mux8way_rr_arbiter;

   localparam int unsigned WIDTH = 16;

   logic                 clk;
   logic                 reset;
   logic [7:0]           in_valid;
   logic [8*WIDTH-1:0]   in_data;
   logic [7:0]           in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [2:0]           out_sel;
   logic                 out_ready;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model state.
   bit               m_full;
   int               m_ptr;
   logic [WIDTH-1:0] m_data;
   logic [2:0]       m_sel;

   mux8way_rr_arbiter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_winner();
      if (m_full && !out_ready) return -1;
      for (int d = 0; d < 8; d++) begin
         int k;
         k = (m_ptr + d) % 8;
         if (in_valid[k]) return k;
      end
      return -1;
   endfunction

   function automatic logic [7:0] model_ready();
      int w;
      w = model_winner();
      if (reset || w < 0) return 8'h00;
      return 8'(1 << w);
   endfunction

   task automatic model_reset();
      m_full = 1'b0;
      m_ptr  = 0;
      m_data = '0;
      m_sel  = '0;
   endtask

   task automatic model_edge();
      int w;
      w = model_winner();
      if (w >= 0) begin
         m_data = in_data[w*WIDTH +: WIDTH];
         m_sel  = 3'(w);
         m_full = 1'b1;
         m_ptr  = (w + 1) % 8;
      end else if (m_full && out_ready) begin
         m_full = 1'b0;
      end
   endtask

   // Advance one clock edge, update the model, and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_edge();
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 8'hFF;
      in_data   = '1;
      out_ready = 1'b1;
      model_reset();
      #3;
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 3'd0 || in_ready !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_hold: valid=%b data=%h sel=%0d ready=%b, required 0/0/0/00000000",
                  out_valid, out_data, out_sel, in_ready);
      end
      @(posedge clk);
      #1;
      reset    = 1'b0;
      in_valid = 8'h00;
      for (int c = 0; c < 4; c++) begin
         #1;
         n_tests++;
         if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: valid=%b ready=%b, required 0/00000000", c, out_valid, in_ready);
         end
         tick();
      end
   endtask

   task automatic test_single();
      do_reset();
      in_valid  = 8'b0000_0100;
      in_data   = '0;
      in_data[2*WIDTH +: WIDTH] = 16'h00A5;
      in_data[1*WIDTH +: WIDTH] = 16'h0011;
      out_ready = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 8'b0000_0100) begin
         n_fail++;
         $display("FAIL single_grant: in_ready=%b, required 00000100", in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 16'h00A5 || out_sel !== 3'd2) begin
         n_fail++;
         $display("FAIL single_out: valid=%b data=%h sel=%0d, required 1/00a5/2", out_valid, out_data, out_sel);
      end
      in_valid = 8'b0000_0110;
      #1;
      n_tests++;
      if (in_ready !== 8'b0000_0010) begin
         n_fail++;
         $display("FAIL single_ptr_after: in_ready=%b, required 00000010", in_ready);
      end
      tick();
   endtask

   task automatic test_stream();
      do_reset();
      in_valid  = 8'hFF;
      for (int k = 0; k < 8; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(k);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         logic [7:0] er;
         er = 8'(1 << (i % 8));
         #1;
         n_tests++;
         if (in_ready !== er) begin
            n_fail++;
            $display("FAIL stream_ready[%0d]: in_ready=%b, required %b", i, in_ready, er);
         end
         tick();
         n_tests++;
         if (out_valid !== 1'b1 || out_sel !== 3'(i % 8) || out_data !== WIDTH'(i % 8)) begin
            n_fail++;
            $display("FAIL stream_out[%0d]: valid=%b sel=%0d data=%h, required 1/%0d/%0d",
                     i, out_valid, out_sel, out_data, i % 8, i % 8);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid  = 8'hFF;
      for (int k = 0; k < 8; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(16'h100 + k);
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (in_ready !== 8'h00) begin
            n_fail++;
            $display("FAIL bp_ready[%0d]: in_ready=%b, required 00000000", c, in_ready);
         end
         tick();
         n_tests++;
         if (out_valid !== 1'b1 || out_sel !== 3'd5 || out_data !== 16'h0105) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: valid=%b sel=%0d data=%h, required 1/5/0105",
                     c, out_valid, out_sel, out_data);
         end
      end
      out_ready = 1'b1;
      #1;
      n_tests++;
      if (in_ready !== 8'b0100_0000) begin
         n_fail++;
         $display("FAIL bp_release: in_ready=%b, required 01000000", in_ready);
      end
      tick();
      n_tests++;
      if (out_sel !== 3'd6 || out_data !== 16'h0106) begin
         n_fail++;
         $display("FAIL bp_next: sel=%0d data=%h, required 6/0106", out_sel, out_data);
      end
   endtask

   task automatic test_wrap();
      logic [7:0] er [3];
      logic [2:0] es [3];
      er[0] = 8'h80; er[1] = 8'h01; er[2] = 8'h80;
      es[0] = 3'd7;  es[1] = 3'd0;  es[2] = 3'd7;
      do_reset();
      for (int k = 0; k < 8; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'(16'hA0 + k);
      out_ready = 1'b1;
      in_valid  = 8'b0100_0000;
      tick();
      in_valid = 8'b1000_0001;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++;
         if (in_ready !== er[i]) begin
            n_fail++;
            $display("FAIL wrap_ready[%0d]: in_ready=%b, required %b", i, in_ready, er[i]);
         end
         tick();
         n_tests++;
         if (out_sel !== es[i]) begin
            n_fail++;
            $display("FAIL wrap_sel[%0d]: sel=%0d, required %0d", i, out_sel, es[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      in_valid  = 8'b0000_0001;
      in_data   = '0;
      in_data[0 +: WIDTH]       = 16'hBEEF;
      in_data[3*WIDTH +: WIDTH] = 16'h3333;
      out_ready = 1'b0;
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL midrst_pre: valid=%b data=%h, required 1/beef", out_valid, out_data);
      end
      in_valid = 8'hFF;
      out_ready = 1'b1;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 3'd0 || in_ready !== 8'h00) begin
         n_fail++;
         $display("FAIL midrst_async: valid=%b data=%h sel=%0d ready=%b, required 0/0/0/00000000",
                  out_valid, out_data, out_sel, in_ready);
      end
      #1;
      reset    = 1'b0;
      in_valid = 8'b0000_1000;
      #1;
      n_tests++;
      if (in_ready !== 8'b0000_1000) begin
         n_fail++;
         $display("FAIL midrst_regrant: in_ready=%b, required 00001000", in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 3'd3 || out_data !== 16'h3333) begin
         n_fail++;
         $display("FAIL midrst_out: valid=%b sel=%0d data=%h, required 1/3/3333", out_valid, out_sel, out_data);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic [7:0] er;
         in_valid = 8'($urandom) & 8'($urandom) & ((c % 50 < 10) ? 8'hFF : 8'($urandom));
         for (int k = 0; k < 8; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         #1;
         er = model_ready();
         n_tests++;
         if (in_ready !== er) begin
            n_fail++;
            $display("FAIL rand_ready[%0d]: in_ready=%b, required %b (in_valid=%b)", c, in_ready, er, in_valid);
         end
         n_tests++;
         if (out_valid !== m_full || (m_full && (out_data !== m_data || out_sel !== m_sel))) begin
            n_fail++;
            $display("FAIL rand_out[%0d]: valid=%b data=%h sel=%0d, required %b/%h/%0d",
                     c, out_valid, out_data, out_sel, m_full, m_data, m_sel);
         end
         tick();
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = '0;
      in_data   = '0;
      out_ready = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
